// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level and rejects bounce shorter than STABLE_CYCLES.
// Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_cnt output.
//
// state      | meaning
// IDLE_LOW   | dout=0, synchronized input agrees
// WAIT_HIGH  | s went high, counting stable-high edges
// IDLE_HIGH  | dout=1, synchronized input agrees
// WAIT_LOW   | s went low, counting stable-low edges
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       dout,
  output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_sync: STABLE_CYCLES must be >= 2");
  end
  if (longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_cnt
    $error("debounce_sync: STABLE_CYCLES exceeds CNT_W counter range");
  end

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   dout_q;
  logic                   busy_q;

  // din enters the first flop directly; nothing combinational ahead of it.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE_LOW: begin
          if (s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            dout_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q;
  logic       glitch_d;

  // An abort is a WAIT_* state seeing s return to the level it started from.
  assign glitch_d = ((state_q == WAIT_HIGH) && !s) || ((state_q == WAIT_LOW) && s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_cnt_q <= '0;
    end else if (glitch_d && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_q <= glitch_cnt_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length reference model predicts
// dout/busy/glitch count per edge; a monitor compares each cycle.
module tb_debounce_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic dout;
  logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  debounce_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .dout(dout),
    .busy(busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic d;
    logic b;
    int   g;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   done   = 0;

  // Reference model: s is din delayed by SYNC_STAGES edges; dout follows s once
  // s has disagreed with dout for STABLE_CYCLES consecutive edges.
  logic m_pipe[$];
  logic m_dout;
  int   m_run;
  int   m_glitch;

  function automatic void model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back(1'b0);
    m_dout   = 1'b0;
    m_run    = 0;
    m_glitch = 0;
  endfunction

  function automatic void model_edge(input logic v);
    logic s;
    s = m_pipe[SYNC_STAGES-1];
    if (s != m_dout) begin
      m_run++;
      if (m_run == STABLE_CYCLES) begin
        m_dout = s;
        m_run  = 0;
      end
    end else begin
      if (m_run > 0 && m_glitch < 255) m_glitch++;
      m_run = 0;
    end
    void'(m_pipe.pop_back());
    m_pipe.push_front(v);
  endfunction

  task automatic tick(input logic v, input logic r);
    exp_t e;
    @(negedge clk);
    #1;
    din   = v;
    reset = r;
    cycle++;
    if (!r) model_reset();
    else model_edge(v);
    e.d = m_dout;
    e.b = (m_run > 0);
    e.g = m_glitch;
    e.cyc = cycle;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v, 1'b1);
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest prediction.
  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dout !== e.d) begin
          errors++;
          $display("FAIL dout cyc=%0d actual=%b expected=%b", e.cyc, dout, e.d);
        end
        checks++;
        if (busy !== e.b) begin
          errors++;
          $display("FAIL busy cyc=%0d actual=%b expected=%b", e.cyc, busy, e.b);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checks++;
        if (int'(glitch_cnt) != e.g) begin
          errors++;
          $display("FAIL glitch_cnt cyc=%0d actual=%0d expected=%0d", e.cyc, glitch_cnt, e.g);
        end
`endif
      end
    end
  end

  task automatic check_now(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, expv);
    end
  endtask

  initial begin : stim
    int lvl;
    model_reset();

    // Reset held with din=1, then released with din=1 held.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    hold(1'b1, 14);

    // Clean fall, rise and fall.
    hold(1'b0, 20);
    hold(1'b1, 20);
    hold(1'b0, 20);

    // Short glitch.
    hold(1'b1, 5);
    hold(1'b0, 15);

    // Bounce then settle.
    hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 2);
    hold(1'b1, 30);
    hold(1'b0, 20);

    // Asynchronous reset in the middle of qualifying a rise.
    hold(1'b1, SYNC_STAGES + 5);
    check_now("busy_before_reset", busy, 1'b1);
    tick(1'b1, 1'b0);
    #1;
    check_now("dout_async_reset", dout, 1'b0);
    check_now("busy_async_reset", busy, 1'b0);
    tick(1'b1, 1'b0);
    hold(1'b1, 14);
    hold(1'b0, 20);

    // Saturating glitch count, then a pulse of STABLE_CYCLES+SYNC_STAGES.
    for (int i = 0; i < 300; i++) begin
      hold(1'b1, 4);
      hold(1'b0, 12);
    end
    hold(1'b1, STABLE_CYCLES + SYNC_STAGES);
    hold(1'b0, 20);

    // Boundary pulses: one period short of and exactly at the window.
    hold(1'b1, STABLE_CYCLES - 1);
    hold(1'b0, 20);
    hold(1'b1, STABLE_CYCLES);
    hold(1'b0, 20);

    // Randomized segments including occasional resets.
    lvl = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        tick(1'($urandom_range(0, 1)), 1'b0);
      end
      lvl = 1 - lvl;
      hold(1'(lvl), int'($urandom_range(1, 14)));
    end
    hold(1'b0, 20);

    @(negedge clk);
    @(negedge clk);
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
